// File: rtl/axis_deserializer.sv
// axis_deserializer: packs narrow up words into wide down words, first word in lane 0.
// One closed group can wait in the assembly register while the output word is stalled.
module axis_deserializer #(
    parameter int DATA_NB    = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          up_ready,
    input  logic                          up_valid,
    input  logic [DATA_WIDTH-1:0]         up_data,
    input  logic                          up_last,
    input  logic                          down_ready,
    output logic                          down_valid,
    output logic [DATA_WIDTH*DATA_NB-1:0] down_data,
    output logic [DATA_NB-1:0]            down_keep,
    output logic                          down_last
);
    localparam int CW = DATA_NB > 1 ? $clog2(DATA_NB) : 1;
    localparam int DW = DATA_WIDTH * DATA_NB;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      asm_data_q, asm_data_d, merge_data;
    logic [DATA_NB-1:0] asm_keep_q, asm_keep_d, merge_keep;
    logic               asm_last_q, asm_last_d;
    logic               pending_q, pending_d;
    logic               down_valid_q, down_valid_d;
    logic [DW-1:0]      down_data_q, down_data_d;
    logic [DATA_NB-1:0] down_keep_q, down_keep_d;
    logic               down_last_q, down_last_d;
    logic               out_free, up_fire, closing, load;

    assign up_ready = rst & ~pending_q;
    assign out_free = ~down_valid_q | down_ready;
    assign up_fire  = up_valid & up_ready;
    assign closing  = up_fire & (up_last | (cnt_q == CW'(DATA_NB - 1)));
    assign load     = out_free & (closing | pending_q);

    always_comb begin
        merge_data = asm_data_q;
        merge_keep = asm_keep_q;
        for (int i = 0; i < DATA_NB; i++) begin
            if (cnt_q == CW'(i)) begin
                merge_data[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
                merge_keep[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        asm_data_d = asm_data_q;
        asm_keep_d = asm_keep_q;
        asm_last_d = asm_last_q;
        pending_d  = pending_q;
        if (pending_q) begin
            if (out_free) begin
                asm_data_d = '0;
                asm_keep_d = '0;
                asm_last_d = 1'b0;
                pending_d  = 1'b0;
            end
        end else if (up_fire) begin
            if (!closing) begin
                asm_data_d = merge_data;
                asm_keep_d = merge_keep;
                cnt_d      = cnt_q + CW'(1);
            end else begin
                cnt_d      = '0;
                asm_data_d = out_free ? '0 : merge_data;
                asm_keep_d = out_free ? '0 : merge_keep;
                asm_last_d = out_free ? 1'b0 : up_last;
                pending_d  = ~out_free;
            end
        end
    end

    // A pending group always has priority; otherwise the freshly closed group loads.
    always_comb begin
        down_valid_d = load | (down_valid_q & ~down_ready);
        down_data_d  = load ? (pending_q ? asm_data_q : merge_data) : down_data_q;
        down_keep_d  = load ? (pending_q ? asm_keep_q : merge_keep) : down_keep_q;
        down_last_d  = load ? (pending_q ? asm_last_q : up_last) : down_last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            asm_data_q   <= '0;
            asm_keep_q   <= '0;
            asm_last_q   <= 1'b0;
            pending_q    <= 1'b0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_keep_q  <= '0;
            down_last_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_data_q   <= asm_data_d;
            asm_keep_q   <= asm_keep_d;
            asm_last_q   <= asm_last_d;
            pending_q    <= pending_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_keep_q  <= down_keep_d;
            down_last_q  <= down_last_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_keep  = down_keep_q;
    assign down_last  = down_last_q;
endmodule

// File: tb/tb_axis_deserializer.sv
// tb_axis_deserializer: directed vector table, reset/DATA_NB=1 sequences and a random scoreboard run.
module tb_axis_deserializer;
    logic        clk = 1'b0, rst = 1'b0;
    logic        up_valid = 1'b0, up_last = 1'b0, down_ready = 1'b0;
    logic [7:0]  up_data = 8'h00;
    logic        up_ready, down_valid, down_last;
    logic [31:0] down_data;
    logic [3:0]  down_keep;
    logic        up_ready1, down_valid1, down_last1;
    logic [7:0]  down_data1;
    logic [0:0]  down_keep1;
    int          checks = 0, errors = 0;

    typedef struct {
        logic uv; logic [7:0] ud; logic ul; logic dr;
        logic eur; logic edv; logic [31:0] ed; logic [3:0] ek; logic el;
    } vec_t;
    vec_t tbl[$];

    axis_deserializer #(.DATA_NB(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .up_ready(up_ready), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(down_valid),
        .down_data(down_data), .down_keep(down_keep), .down_last(down_last));

    axis_deserializer #(.DATA_NB(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .up_ready(up_ready1), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(down_valid1),
        .down_data(down_data1), .down_keep(down_keep1), .down_last(down_last1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t vec(logic uv, logic [7:0] ud, logic ul, logic dr,
                                 logic eur, logic edv, logic [31:0] ed, logic [3:0] ek, logic el);
        vec_t v;
        v.uv = uv; v.ud = ud; v.ul = ul; v.dr = dr;
        v.eur = eur; v.edv = edv; v.ed = ed; v.ek = ek; v.el = el;
        return v;
    endfunction

    task automatic step(input logic uv, input logic [7:0] ud, input logic ul, input logic dr);
        @(negedge clk);
        up_valid = uv; up_data = ud; up_last = ul; down_ready = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string nm);
        step(v.uv, v.ud, v.ul, v.dr);
        chk(nm, {up_ready, down_valid, down_data, down_keep, down_last},
                {v.eur, v.edv, v.ed, v.ek, v.el});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] md;
    logic [3:0]  mk;
    int          lane;
    logic [36:0] expq[$];
    logic        stalled;
    logic [36:0] held;
    int          words, cyc;

    initial begin
        // stream of full groups, no back-pressure
        tbl.push_back(vec(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(vec(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(vec(1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        tbl.push_back(vec(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h05, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h06, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h07, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h08, 0, 1, 1, 1, 32'h08070605, 4'hF, 0));
        // early close with up_last, then a full group
        tbl.push_back(vec(1, 8'hAA, 0, 1, 1, 0, 32'h08070605, 4'hF, 0));
        tbl.push_back(vec(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1));
        tbl.push_back(vec(1, 8'h11, 0, 1, 1, 0, 32'h0000BBAA, 4'h3, 1));
        tbl.push_back(vec(1, 8'h12, 0, 1, 1, 0, 32'h0000BBAA, 4'h3, 1));
        tbl.push_back(vec(1, 8'h13, 0, 1, 1, 0, 32'h0000BBAA, 4'h3, 1));
        tbl.push_back(vec(1, 8'h14, 0, 1, 1, 1, 32'h14131211, 4'hF, 0));
        tbl.push_back(vec(0, 8'hFF, 1, 1, 1, 0, 32'h14131211, 4'hF, 0));
        tbl.push_back(vec(0, 8'hEE, 1, 1, 1, 0, 32'h14131211, 4'hF, 0));
        // single-word group
        tbl.push_back(vec(1, 8'h5A, 1, 1, 1, 1, 32'h0000005A, 4'h1, 1));
        tbl.push_back(vec(0, 8'h00, 0, 1, 1, 0, 32'h0000005A, 4'h1, 1));
        // back-pressure: one output word plus one pending group
        tbl.push_back(vec(1, 8'h01, 0, 0, 1, 0, 32'h0000005A, 4'h1, 1));
        tbl.push_back(vec(1, 8'h02, 0, 0, 1, 0, 32'h0000005A, 4'h1, 1));
        tbl.push_back(vec(1, 8'h03, 0, 0, 1, 0, 32'h0000005A, 4'h1, 1));
        tbl.push_back(vec(1, 8'h04, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h06, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h07, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h08, 0, 0, 0, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h09, 0, 0, 0, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h09, 0, 0, 0, 1, 32'h04030201, 4'hF, 0));
        tbl.push_back(vec(1, 8'h09, 0, 1, 1, 1, 32'h08070605, 4'hF, 0));
        tbl.push_back(vec(1, 8'h09, 0, 1, 1, 0, 32'h08070605, 4'hF, 0));
        tbl.push_back(vec(1, 8'h0A, 0, 1, 1, 0, 32'h08070605, 4'hF, 0));
        tbl.push_back(vec(1, 8'h0B, 0, 1, 1, 0, 32'h08070605, 4'hF, 0));
        tbl.push_back(vec(1, 8'h0C, 0, 1, 1, 1, 32'h0C0B0A09, 4'hF, 0));
        tbl.push_back(vec(0, 8'h00, 0, 1, 1, 0, 32'h0C0B0A09, 4'hF, 0));

        #1;
        chk("reset dut", {up_ready, down_valid, down_data, down_keep, down_last}, 38'h0);
        chk("reset dut1", {up_ready1, down_valid1, down_data1, down_keep1, down_last1}, 12'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("up_ready after release", up_ready, 1);

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

        // reset in the middle of a group while an output word is stalled
        step(1, 8'h5A, 1, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        chk("pre-reset valid", down_valid, 1);
        @(negedge clk);
        up_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async reset", {up_ready, down_valid, down_data, down_keep, down_last}, 38'h0);
        @(negedge clk);
        rst = 1'b1;
        apply(vec(1, 8'h31, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post-reset 31");
        apply(vec(1, 8'h32, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post-reset 32");
        apply(vec(1, 8'h33, 0, 1, 1, 0, 32'h0, 4'h0, 0), "post-reset 33");
        apply(vec(1, 8'h34, 0, 1, 1, 1, 32'h34333231, 4'hF, 0), "post-reset 34");

        // DATA_NB=1 pass-through
        step(1, 8'h5A, 0, 1);
        chk("nb1 5A", {down_valid1, down_data1, down_keep1, down_last1}, {1'b1, 8'h5A, 1'b1, 1'b0});
        step(1, 8'h6B, 0, 1);
        chk("nb1 6B", {down_valid1, down_data1, down_keep1, down_last1}, {1'b1, 8'h6B, 1'b1, 1'b0});
        step(0, 8'h00, 0, 1);
        chk("nb1 idle", down_valid1, 0);

        // random traffic against a grouping scoreboard
        do_reset();
        md = '0; mk = '0; lane = 0; stalled = 1'b0; held = '0; words = 0; cyc = 0;
        while (words < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (stalled)
                chk("stable", {down_valid, down_data, down_keep, down_last}, {1'b1, held});
            up_valid   = ($urandom_range(0, 3) != 0);
            up_data    = 8'($urandom);
            up_last    = ($urandom_range(0, 4) == 0);
            down_ready = ($urandom_range(0, 3) != 0);
            if (up_valid && up_ready) begin
                words++;
                md[lane*8 +: 8] = up_data;
                mk[lane] = 1'b1;
                if (lane == 3 || up_last) begin
                    expq.push_back({md, mk, up_last});
                    md = '0; mk = '0; lane = 0;
                end else lane++;
            end
            if (down_valid && down_ready) begin
                if (expq.size() == 0) chk("extra word", 1, 0);
                else chk("rand word", {down_data, down_keep, down_last}, expq.pop_front());
            end
            stalled = down_valid & ~down_ready;
            held = {down_data, down_keep, down_last};
        end
        chk("word budget", words, 10000);
        up_valid = 1'b0;
        down_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (down_valid) begin
                if (expq.size() == 0) chk("extra word", 1, 0);
                else chk("drain word", {down_data, down_keep, down_last}, expq.pop_front());
            end
        end
        chk("drain empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
